// File: rtl/display_timing_gen_if.sv
// Timing-set load channel for display_timing_gen: one valid/ready offer
// carrying a full horizontal/vertical timing set, plus an error pulse back.
interface display_timing_gen_if #(
    parameter int CORDW = 12
);
    logic             cfg_valid;
    logic             cfg_ready;
    logic [CORDW-1:0] cfg_h_active;
    logic [CORDW-1:0] cfg_h_fp;
    logic [CORDW-1:0] cfg_h_sync;
    logic [CORDW-1:0] cfg_h_bp;
    logic [CORDW-1:0] cfg_v_active;
    logic [CORDW-1:0] cfg_v_fp;
    logic [CORDW-1:0] cfg_v_sync;
    logic [CORDW-1:0] cfg_v_bp;
    logic             cfg_hpol;
    logic             cfg_vpol;
    logic             cfg_err;

    modport master (
        output cfg_valid, cfg_h_active, cfg_h_fp, cfg_h_sync, cfg_h_bp,
               cfg_v_active, cfg_v_fp, cfg_v_sync, cfg_v_bp, cfg_hpol, cfg_vpol,
        input  cfg_ready, cfg_err
    );

    modport slave (
        input  cfg_valid, cfg_h_active, cfg_h_fp, cfg_h_sync, cfg_h_bp,
               cfg_v_active, cfg_v_fp, cfg_v_sync, cfg_v_bp, cfg_hpol, cfg_vpol,
        output cfg_ready, cfg_err
    );
endinterface

// File: rtl/display_timing_gen.sv
// Runtime-reconfigurable display timing generator; a loaded timing set is
// held pending and swapped in only at the end-of-frame wrap.
module display_timing_gen #(
    parameter int CORDW    = 12,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit H_POL    = 1'b0,
    parameter bit V_POL    = 1'b0
) (
    input  logic                clk_pix,
    input  logic                rst,
    display_timing_gen_if.slave cfg,
    output logic [CORDW-1:0]    sx,
    output logic [CORDW-1:0]    sy,
    output logic                hsync,
    output logic                vsync,
    output logic                de,
    output logic                line,
    output logic                frame,
    output logic [15:0]         frame_cnt
);
    localparam int BW = CORDW + 2;
    localparam logic [BW-1:0] MAX_TOT = {2'b01, {CORDW{1'b0}}};

    typedef struct packed {
        logic [CORDW-1:0] ha;
        logic [CORDW-1:0] hf;
        logic [CORDW-1:0] hs;
        logic [CORDW-1:0] hb;
        logic [CORDW-1:0] va;
        logic [CORDW-1:0] vf;
        logic [CORDW-1:0] vs;
        logic [CORDW-1:0] vb;
        logic             hp;
        logic             vp;
    } timing_t;

    timing_t          r_act, r_pend;
    logic             r_pend_full;
    logic [CORDW-1:0] r_hc, r_vc;
    logic [CORDW-1:0] r_sx, r_sy;
    logic             r_hsync, r_vsync, r_de, r_line, r_frame, r_cfg_err;
    logic [15:0]      r_frame_cnt;

    timing_t          w_def, w_cfg;
    logic [BW-1:0]    w_hc, w_vc;
    logic [BW-1:0]    w_ha_end, w_hs_sta, w_hs_end, w_line;
    logic [BW-1:0]    w_va_end, w_vs_sta, w_vs_end, w_screen;
    logic [BW-1:0]    w_htot_cfg, w_vtot_cfg;
    logic             w_cfg_bad, w_ready, w_accept, w_wrap, w_hs_on, w_vs_on;

    always_comb begin
        w_def = '{ha: CORDW'(H_ACTIVE), hf: CORDW'(H_FP), hs: CORDW'(H_SYNC), hb: CORDW'(H_BP),
                  va: CORDW'(V_ACTIVE), vf: CORDW'(V_FP), vs: CORDW'(V_SYNC), vb: CORDW'(V_BP),
                  hp: H_POL, vp: V_POL};
        w_cfg = '{ha: cfg.cfg_h_active, hf: cfg.cfg_h_fp, hs: cfg.cfg_h_sync, hb: cfg.cfg_h_bp,
                  va: cfg.cfg_v_active, vf: cfg.cfg_v_fp, vs: cfg.cfg_v_sync, vb: cfg.cfg_v_bp,
                  hp: cfg.cfg_hpol, vp: cfg.cfg_vpol};
    end

    // Widened by two bits so the sums of four CORDW fields never overflow.
    always_comb begin
        w_hc     = {2'b00, r_hc};
        w_vc     = {2'b00, r_vc};
        w_ha_end = BW'(r_act.ha) - BW'(1);
        w_hs_sta = BW'(r_act.ha) + BW'(r_act.hf);
        w_hs_end = w_hs_sta + BW'(r_act.hs);
        w_line   = w_hs_end + BW'(r_act.hb) - BW'(1);
        w_va_end = BW'(r_act.va) - BW'(1);
        w_vs_sta = BW'(r_act.va) + BW'(r_act.vf);
        w_vs_end = w_vs_sta + BW'(r_act.vs);
        w_screen = w_vs_end + BW'(r_act.vb) - BW'(1);
        w_hs_on  = (w_hc >= w_hs_sta) && (w_hc < w_hs_end);
        w_vs_on  = (w_vc >= w_vs_sta) && (w_vc < w_vs_end);
        w_wrap   = (w_hc == w_line) && (w_vc == w_screen);
    end

    always_comb begin
        w_htot_cfg = BW'(w_cfg.ha) + BW'(w_cfg.hf) + BW'(w_cfg.hs) + BW'(w_cfg.hb);
        w_vtot_cfg = BW'(w_cfg.va) + BW'(w_cfg.vf) + BW'(w_cfg.vs) + BW'(w_cfg.vb);
        w_cfg_bad  = (w_cfg.ha == '0) || (w_cfg.hs == '0) || (w_cfg.va == '0) || (w_cfg.vs == '0)
                  || (w_htot_cfg > MAX_TOT) || (w_vtot_cfg > MAX_TOT);
        w_ready    = !r_pend_full && !rst;
        w_accept   = cfg.cfg_valid && w_ready;
    end

    always_ff @(posedge clk_pix) begin
        if (rst) begin
            r_act       <= w_def;
            r_pend      <= w_def;
            r_pend_full <= 1'b0;
            r_hc        <= '0;
            r_vc        <= '0;
            r_sx        <= '0;
            r_sy        <= '0;
            r_hsync     <= ~H_POL;
            r_vsync     <= ~V_POL;
            r_de        <= 1'b0;
            r_line      <= 1'b0;
            r_frame     <= 1'b0;
            r_cfg_err   <= 1'b0;
            r_frame_cnt <= '0;
        end else begin
            r_sx      <= r_hc;
            r_sy      <= r_vc;
            r_hsync   <= w_hs_on ? r_act.hp : ~r_act.hp;
            r_vsync   <= w_vs_on ? r_act.vp : ~r_act.vp;
            r_de      <= (w_hc <= w_ha_end) && (w_vc <= w_va_end);
            r_line    <= (r_hc == '0);
            r_frame   <= (r_hc == '0) && (r_vc == '0);
            r_cfg_err <= w_accept && w_cfg_bad;
            if ((r_hc == '0) && (r_vc == '0)) begin
                r_frame_cnt <= r_frame_cnt + 16'd1;
            end
            if (w_hc == w_line) begin
                r_hc <= '0;
                r_vc <= (w_vc == w_screen) ? '0 : r_vc + 1'b1;
            end else begin
                r_hc <= r_hc + 1'b1;
            end
            // Accept needs an empty pending slot, so it never collides with the swap.
            if (w_wrap && r_pend_full) begin
                r_act       <= r_pend;
                r_pend_full <= 1'b0;
            end
            if (w_accept && !w_cfg_bad) begin
                r_pend      <= w_cfg;
                r_pend_full <= 1'b1;
            end
        end
    end

    assign cfg.cfg_ready = w_ready;
    assign cfg.cfg_err   = r_cfg_err;
    assign sx            = r_sx;
    assign sy            = r_sy;
    assign hsync         = r_hsync;
    assign vsync         = r_vsync;
    assign de            = r_de;
    assign line          = r_line;
    assign frame         = r_frame;
    assign frame_cnt     = r_frame_cnt;
endmodule

// File: tb/tb_display_timing_gen.sv
// Randomized scoreboard bench for display_timing_gen: a frame-position model
// predicts every output cycle; a monitor pops and compares each cycle.
module tb_display_timing_gen;
    localparam int CW = 6;
    localparam int LIM = 1 << CW;
    localparam int HA = 8, HF = 2, HS = 3, HB = 2;
    localparam int VA = 4, VF = 1, VS = 2, VB = 1;
    localparam bit HP = 1'b0, VP = 1'b0;

    typedef struct {
        int ha, hf, hs, hb, va, vf, vs, vb;
        bit hp, vp;
    } tset_t;

    typedef struct {
        int sx, sy, fc;
        bit hs, vs, de, ln, fr, er, rd;
    } exp_t;

    logic          clk_pix = 1'b0;
    logic          rst     = 1'b1;
    logic [CW-1:0] sx, sy;
    logic          hsync, vsync, de, line, frame;
    logic [15:0]   frame_cnt;

    display_timing_gen_if #(.CORDW(CW)) ifc ();

    display_timing_gen #(
        .CORDW(CW), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .H_POL(HP), .V_POL(VP)
    ) dut (
        .clk_pix(clk_pix), .rst(rst), .cfg(ifc),
        .sx(sx), .sy(sy), .hsync(hsync), .vsync(vsync), .de(de),
        .line(line), .frame(frame), .frame_cnt(frame_cnt)
    );

    always #5 clk_pix = ~clk_pix;

    int    total = 0;
    int    bad   = 0;
    exp_t  expq[$];
    tset_t m_cur, m_pend;
    bit    m_pend_full = 1'b0;
    int    m_t = 0;
    int    m_fc = 0;

    function automatic tset_t defaults();
        tset_t c;
        c = '{ha: HA, hf: HF, hs: HS, hb: HB, va: VA, vf: VF, vs: VS, vb: VB, hp: HP, vp: VP};
        return c;
    endfunction

    function automatic int htot(input tset_t c);
        return c.ha + c.hf + c.hs + c.hb;
    endfunction

    function automatic int vtot(input tset_t c);
        return c.va + c.vf + c.vs + c.vb;
    endfunction

    function automatic bit legal(input tset_t c);
        return c.ha > 0 && c.hs > 0 && c.va > 0 && c.vs > 0 && htot(c) <= LIM && vtot(c) <= LIM;
    endfunction

    function automatic tset_t bus_cfg();
        tset_t c;
        c = '{ha: int'(ifc.cfg_h_active), hf: int'(ifc.cfg_h_fp), hs: int'(ifc.cfg_h_sync),
              hb: int'(ifc.cfg_h_bp), va: int'(ifc.cfg_v_active), vf: int'(ifc.cfg_v_fp),
              vs: int'(ifc.cfg_v_sync), vb: int'(ifc.cfg_v_bp), hp: ifc.cfg_hpol, vp: ifc.cfg_vpol};
        return c;
    endfunction

    function automatic tset_t rnd_cfg();
        tset_t c;
        c.ha = $urandom_range(1, 16);
        c.hf = $urandom_range(0, 4);
        c.hs = $urandom_range(1, 4);
        c.hb = $urandom_range(0, 4);
        c.va = $urandom_range(1, 6);
        c.vf = $urandom_range(0, 2);
        c.vs = $urandom_range(1, 2);
        c.vb = $urandom_range(0, 2);
        c.hp = 1'($urandom_range(0, 1));
        c.vp = 1'($urandom_range(0, 1));
        return c;
    endfunction

    function automatic tset_t bad_cfg();
        tset_t c;
        c = rnd_cfg();
        case ($urandom_range(0, 4))
            0:       c.ha = 0;
            1:       c.hs = 0;
            2:       c.va = 0;
            3:       c.vs = 0;
            default: begin c.ha = 63; c.hs = 2; end
        endcase
        return c;
    endfunction

    // Reference model: outputs follow from the position inside the frame.
    always @(posedge clk_pix) begin
        exp_t  e;
        tset_t c;
        int    ht, vt, x, y;
        bit    acc;
        e = '{default: 0};
        if (rst) begin
            m_cur       = defaults();
            m_pend_full = 1'b0;
            m_t         = 0;
            m_fc        = 0;
            e.hs        = !HP;
            e.vs        = !VP;
        end else begin
            ht   = htot(m_cur);
            vt   = vtot(m_cur);
            x    = m_t % ht;
            y    = m_t / ht;
            e.sx = x;
            e.sy = y;
            e.de = (x < m_cur.ha) && (y < m_cur.va);
            e.hs = (x >= m_cur.ha + m_cur.hf && x < m_cur.ha + m_cur.hf + m_cur.hs) ? m_cur.hp : !m_cur.hp;
            e.vs = (y >= m_cur.va + m_cur.vf && y < m_cur.va + m_cur.vf + m_cur.vs) ? m_cur.vp : !m_cur.vp;
            e.ln = (x == 0);
            e.fr = (m_t == 0);
            if (m_t == 0) m_fc = (m_fc + 1) % 65536;
            e.fc = m_fc;
            acc  = ifc.cfg_valid && !m_pend_full;
            if (m_t == ht * vt - 1) begin
                m_t = 0;
                if (m_pend_full) begin
                    m_cur       = m_pend;
                    m_pend_full = 1'b0;
                end
            end else begin
                m_t++;
            end
            if (acc) begin
                c = bus_cfg();
                if (legal(c)) begin
                    m_pend      = c;
                    m_pend_full = 1'b1;
                end else begin
                    e.er = 1'b1;
                end
            end
            e.rd = !m_pend_full;
        end
        expq.push_back(e);
    end

    always @(posedge clk_pix) begin
        exp_t e;
        #1;
        total++;
        if (expq.size() == 0) begin
            bad++;
            $display("FAIL scoreboard_empty at %0t: no expected entry for this cycle", $time);
        end else begin
            e = expq.pop_front();
            if (int'(sx) != e.sx || int'(sy) != e.sy || hsync !== e.hs || vsync !== e.vs ||
                de !== e.de || line !== e.ln || frame !== e.fr || int'(frame_cnt) != e.fc ||
                ifc.cfg_err !== e.er || ifc.cfg_ready !== e.rd) begin
                bad++;
                $display("FAIL outputs at %0t: got sx=%0d sy=%0d hs=%0b vs=%0b de=%0b line=%0b frame=%0b fcnt=%0d err=%0b rdy=%0b, want sx=%0d sy=%0d hs=%0b vs=%0b de=%0b line=%0b frame=%0b fcnt=%0d err=%0b rdy=%0b",
                         $time, sx, sy, hsync, vsync, de, line, frame, frame_cnt, ifc.cfg_err, ifc.cfg_ready,
                         e.sx, e.sy, e.hs, e.vs, e.de, e.ln, e.fr, e.fc, e.er, e.rd);
            end
        end
    end

    task automatic drive(input tset_t c);
        ifc.cfg_h_active = CW'(c.ha);
        ifc.cfg_h_fp     = CW'(c.hf);
        ifc.cfg_h_sync   = CW'(c.hs);
        ifc.cfg_h_bp     = CW'(c.hb);
        ifc.cfg_v_active = CW'(c.va);
        ifc.cfg_v_fp     = CW'(c.vf);
        ifc.cfg_v_sync   = CW'(c.vs);
        ifc.cfg_v_bp     = CW'(c.vb);
        ifc.cfg_hpol     = c.hp;
        ifc.cfg_vpol     = c.vp;
    endtask

    // Called on a falling edge; holds valid until the handshake completes.
    task automatic offer(input tset_t c, input int idle);
        int n;
        n = 0;
        drive(c);
        ifc.cfg_valid = 1'b1;
        while (ifc.cfg_ready !== 1'b1) begin
            @(negedge clk_pix);
            n++;
            if (n > 20000) begin
                $display("FAIL handshake_timeout: cfg_ready=%0b required=1", ifc.cfg_ready);
                $fatal(1, "handshake never completed");
            end
        end
        @(negedge clk_pix);
        ifc.cfg_valid = 1'b0;
        repeat (idle) @(negedge clk_pix);
    endtask

    task automatic offer_on_wrap(input tset_t c);
        int n;
        n = 0;
        while (m_pend_full || m_t != htot(m_cur) * vtot(m_cur) - 1) begin
            @(negedge clk_pix);
            n++;
            if (n > 20000) begin
                $display("FAIL wrap_wait_timeout: pend_full=%0b required=0", m_pend_full);
                $fatal(1, "wrap cycle never reached");
            end
        end
        drive(c);
        ifc.cfg_valid = 1'b1;
        @(negedge clk_pix);
        ifc.cfg_valid = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tset_t big, c;
        ifc.cfg_valid = 1'b0;
        drive(defaults());
        rst = 1'b1;
        repeat (4) @(negedge clk_pix);
        rst = 1'b0;
        repeat (250) @(negedge clk_pix);

        big = '{ha: 20, hf: 3, hs: 2, hb: 4, va: 6, vf: 1, vs: 1, vb: 2, hp: 1'b1, vp: 1'b1};
        offer(big, 0);
        offer(rnd_cfg(), 600);

        c = defaults();
        c.hs = 0;
        offer(c, 50);

        c = '{ha: 58, hf: 1, hs: 4, hb: 1, va: 2, vf: 0, vs: 1, vb: 0, hp: 1'b1, vp: 1'b0};
        offer(c, 0);
        c.ha = 59;
        offer(c, 0);
        c = '{ha: 2, hf: 0, hs: 1, hb: 0, va: 60, vf: 1, vs: 2, vb: 1, hp: 1'b0, vp: 1'b1};
        offer(c, 0);
        c.va = 61;
        offer(c, 250);

        offer_on_wrap(rnd_cfg());
        repeat (400) @(negedge clk_pix);

        for (int i = 0; i < 25; i++) begin
            c = ($urandom_range(0, 6) == 0) ? bad_cfg() : rnd_cfg();
            offer(c, $urandom_range(0, 300));
            if ($urandom_range(0, 7) == 0) begin
                rst = 1'b1;
                repeat ($urandom_range(1, 4)) @(negedge clk_pix);
                rst = 1'b0;
            end
        end

        offer_on_wrap(rnd_cfg());
        repeat (300) @(negedge clk_pix);

        offer(big, 0);
        repeat (400) @(negedge clk_pix);
        rst = 1'b1;
        repeat (3) @(negedge clk_pix);
        rst = 1'b0;
        repeat (300) @(negedge clk_pix);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
